lct_link_unpack: RTL and testbench

LCT_LINK_UNPACK -- requirements
Module: lct_link_unpack

---
 rtl/lct_link_unpack_pkg.sv | 47 ++++
 rtl/lct_link_unpack_word_decode.sv | 24 ++
 rtl/lct_link_unpack.sv | 199 +++++++++++++++++++
 tb/tb_lct_link_unpack.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lct_link_unpack_pkg.sv
// Shared spbits constants, field offsets and types for the LCT link unpacker.
package lct_link_unpack_pkg;

  localparam int unsigned SEG_CH  = 2;
  localparam int unsigned NUM_CH  = 9;
  localparam int unsigned BW_WG   = 7;
  localparam int unsigned BW_HS   = 8;
  localparam int unsigned BW_Q    = 4;
  localparam int unsigned BW_CPAT = 4;

  localparam logic [7:0] K_HDR = 8'hBC;
  localparam logic [7:0] K_TRL = 8'hFD;

  localparam int unsigned OFS_VPF    = 31;
  localparam int unsigned OFS_SEG    = 30;
  localparam int unsigned OFS_CSC    = 26;
  localparam int unsigned OFS_Q      = 22;
  localparam int unsigned OFS_WG     = 15;
  localparam int unsigned OFS_HS     = 7;
  localparam int unsigned OFS_CPAT   = 3;
  localparam int unsigned OFS_BX3    = 0;
  localparam int unsigned OFS_HDR_BX = 12;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_COUNT  = 3'd1,
    ERR_CSCID  = 3'd2,
    ERR_DUP    = 3'd3,
    ERR_CHK    = 3'd4,
    ERR_RESYNC = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_TRL  = 2'd2
  } state_e;

  typedef struct packed {
    logic               vpf;
    logic [BW_Q-1:0]    q;
    logic [BW_WG-1:0]   wg;
    logic [BW_HS-1:0]   hs;
    logic [BW_CPAT-1:0] cpat;
  } lct_t;

endpackage

// File: rtl/lct_link_unpack_word_decode.sv
// Combinational field extraction of one link data word plus cscid and bx sanity checks.
module lct_word_decode
  import lct_link_unpack_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  hdr_bx3,
  output lct_t        lct_c,
  output logic [3:0]  cscid_c,
  output logic        seg_c,
  output logic        field_err_c
);

  always_comb begin
    lct_c.vpf   = word[OFS_VPF];
    lct_c.q     = word[OFS_Q +: BW_Q];
    lct_c.wg    = word[OFS_WG +: BW_WG];
    lct_c.hs    = word[OFS_HS +: BW_HS];
    lct_c.cpat  = word[OFS_CPAT +: BW_CPAT];
    cscid_c     = word[OFS_CSC +: 4];
    seg_c       = word[OFS_SEG];
    field_err_c = (cscid_c > 4'd8) || (word[OFS_BX3 +: 3] != hdr_bx3);
  end

endmodule

// File: rtl/lct_link_unpack.sv
// Unpacks framed LCT link words into a shadow array and publishes it on a good trailer.
module lct_link_unpack
  import lct_link_unpack_pkg::*;
#(
  parameter int unsigned station = 0,
  parameter int unsigned seg_ch  = SEG_CH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [31:0]                            link_d,
  input  logic                                   link_k,
  input  logic                                   link_vld,
  output logic [8:0][seg_ch-1:0]                 vpf,
  output logic [8:0][seg_ch-1:0][BW_Q-1:0]       q,
  output logic [8:0][seg_ch-1:0][BW_WG-1:0]      wg,
  output logic [8:0][seg_ch-1:0][BW_HS-1:0]      hstr,
  output logic [8:0][seg_ch-1:0][BW_CPAT-1:0]    cpat,
  output logic                                   lct_stb,
  output logic [11:0]                            bx_out,
  output logic [15:0]                            err_cnt,
  output logic [2:0]                             err_code
);

  localparam int unsigned MAX_N = NUM_CH * seg_ch;

  if (station > 4) begin : g_bad_station
    $error("lct_link_unpack: station must be 0..4");
  end

  state_e                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [11:0]             bx_hdr_q, bx_hdr_d;
  logic [23:0]             chk_q, chk_d;
  logic                    bad_q, bad_d;
  lct_t [8:0][seg_ch-1:0]  shadow_q, shadow_d;
  lct_t [8:0][seg_ch-1:0]  out_q, out_d;
  logic [11:0]             bx_out_q, bx_out_d;
  logic                    stb_q, stb_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  err_code_e               err_code_q, err_code_d;

  lct_t       lct_c;
  logic [3:0] cscid_c;
  logic       seg_c;
  logic       field_err_c;
  logic       hdr_w, trl_w, n_bad, seg_bad, start, take;
  logic [4:0] n_w;
  err_code_e  ev;

  lct_word_decode u_dec (
    .word        (link_d),
    .hdr_bx3     (bx_hdr_q[2:0]),
    .lct_c       (lct_c),
    .cscid_c     (cscid_c),
    .seg_c       (seg_c),
    .field_err_c (field_err_c)
  );

  assign hdr_w   = link_k && (link_d[31:24] == K_HDR);
  assign trl_w   = link_k && (link_d[31:24] == K_TRL);
  assign n_w     = link_d[4:0];
  assign n_bad   = 32'(n_w) > MAX_N;
  assign seg_bad = int'(seg_c) >= int'(seg_ch);

  // Frame FSM; at most one error is counted per cycle, and only the first per frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bx_hdr_d   = bx_hdr_q;
    chk_d      = chk_q;
    bad_d      = bad_q;
    shadow_d   = shadow_q;
    out_d      = out_q;
    bx_out_d   = bx_out_q;
    stb_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    err_code_d = err_code_q;
    start      = 1'b0;
    take       = 1'b0;
    ev         = ERR_NONE;

    if (link_vld) begin
      case (state_q)
        ST_HUNT: start = hdr_w;
        ST_DATA: begin
          if (link_k) begin
            take    = !bad_q;
            ev      = ERR_RESYNC;
            start   = hdr_w;
            state_d = ST_HUNT;
          end else begin
            cnt_d = cnt_q - 5'd1;
            chk_d = chk_q ^ link_d[23:0];
            if (cnt_q == 5'd1) state_d = ST_TRL;
            if (field_err_c || seg_bad) begin
              take  = !bad_q;
              ev    = ERR_CSCID;
              bad_d = 1'b1;
            end else if (lct_c.vpf) begin
              for (int c = 0; c < int'(NUM_CH); c++) begin
                for (int s = 0; s < int'(seg_ch); s++) begin
                  if (c == int'(cscid_c) && s == int'(seg_c)) begin
                    if (shadow_q[c][s].vpf) begin
                      take  = !bad_q;
                      ev    = ERR_DUP;
                      bad_d = 1'b1;
                    end
                    shadow_d[c][s] = lct_c;
                  end
                end
              end
            end
          end
        end
        ST_TRL: begin
          state_d = ST_HUNT;
          if (trl_w && (link_d[23:0] == chk_q)) begin
            if (!bad_q) begin
              out_d    = shadow_q;
              bx_out_d = bx_hdr_q;
              stb_d    = 1'b1;
            end
          end else begin
            take = !bad_q;
            ev   = ERR_CHK;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // A header (from HUNT, or resync from DATA) opens a fresh frame.
    if (start) begin
      shadow_d = '0;
      chk_d    = '0;
      bad_d    = 1'b0;
      bx_hdr_d = link_d[OFS_HDR_BX +: 12];
      cnt_d    = n_w;
      if (n_bad) begin
        state_d = ST_HUNT;
        if (!take) begin
          take = 1'b1;
          ev   = ERR_COUNT;
        end
      end else begin
        state_d = (n_w == 5'd0) ? ST_TRL : ST_DATA;
      end
    end

    if (take) begin
      err_code_d = ev;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      cnt_q      <= '0;
      bx_hdr_q   <= '0;
      chk_q      <= '0;
      bad_q      <= 1'b0;
      shadow_q   <= '0;
      out_q      <= '0;
      bx_out_q   <= '0;
      stb_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bx_hdr_q   <= bx_hdr_d;
      chk_q      <= chk_d;
      bad_q      <= bad_d;
      shadow_q   <= shadow_d;
      out_q      <= out_d;
      bx_out_q   <= bx_out_d;
      stb_q      <= stb_d;
      err_cnt_q  <= err_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar s = 0; s < seg_ch; s++) begin : g_seg
      assign vpf[c][s]  = out_q[c][s].vpf;
      assign q[c][s]    = out_q[c][s].q;
      assign wg[c][s]   = out_q[c][s].wg;
      assign hstr[c][s] = out_q[c][s].hs;
      assign cpat[c][s] = out_q[c][s].cpat;
    end
  end

  assign lct_stb  = stb_q;
  assign bx_out   = bx_out_q;
  assign err_cnt  = err_cnt_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_lct_link_unpack.sv
// Scoreboard bench for lct_link_unpack: directed frames, expected snapshots queued, monitor compares on lct_stb.
module tb_lct_link_unpack;

  typedef struct packed {
    logic [8:0][1:0]      vpf;
    logic [8:0][1:0][3:0] q;
    logic [8:0][1:0][6:0] wg;
    logic [8:0][1:0][7:0] hs;
    logic [8:0][1:0][3:0] cpat;
    logic [11:0]          bx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [31:0]          link_d;
  logic                 link_k;
  logic                 link_vld;
  logic [8:0][1:0]      vpf;
  logic [8:0][1:0][3:0] q;
  logic [8:0][1:0][6:0] wg;
  logic [8:0][1:0][7:0] hstr;
  logic [8:0][1:0][3:0] cpat;
  logic                 lct_stb;
  logic [11:0]          bx_out;
  logic [15:0]          err_cnt;
  logic [2:0]           err_code;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] wq[$];
  exp_t        last_exp;
  exp_t        zero_exp;
  bit          gap_en = 1'b0;
  int          exp_cnt = 0;

  lct_link_unpack #(.station(0), .seg_ch(2)) dut (
    .clk(clk), .rst_n(rst_n), .link_d(link_d), .link_k(link_k), .link_vld(link_vld),
    .vpf(vpf), .q(q), .wg(wg), .hstr(hstr), .cpat(cpat), .lct_stb(lct_stb),
    .bx_out(bx_out), .err_cnt(err_cnt), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, "_vpf"},  256'(vpf),    256'(e.vpf));
    chk({tag, "_q"},    256'(q),      256'(e.q));
    chk({tag, "_wg"},   256'(wg),     256'(e.wg));
    chk({tag, "_hstr"}, 256'(hstr),   256'(e.hs));
    chk({tag, "_cpat"}, 256'(cpat),   256'(e.cpat));
    chk({tag, "_bx"},   256'(bx_out), 256'(e.bx));
  endtask

  task automatic chk_err(input string tag, input int cnt, input logic [2:0] code);
    chk({tag, "_err_cnt"},  256'(err_cnt),  256'(cnt));
    chk({tag, "_err_code"}, 256'(err_code), 256'(code));
  endtask

  function automatic logic [31:0] mk(input logic v, input logic s, input logic [3:0] c,
                                     input logic [3:0] qq, input logic [6:0] w, input logic [7:0] h,
                                     input logic [3:0] cp, input logic [2:0] b);
    return {v, s, c, qq, w, h, cp, b};
  endfunction

  function automatic logic [31:0] hdr(input logic [11:0] bx, input logic [4:0] n);
    return {8'hBC, bx, 7'd0, n};
  endfunction

  // Expected output snapshot for a clean frame built from the queued words.
  function automatic exp_t build(input logic [11:0] bx);
    exp_t e;
    int   c;
    int   s;
    e    = '0;
    e.bx = bx;
    foreach (wq[i]) begin
      if (wq[i][31]) begin
        c = int'(wq[i][29:26]);
        s = int'(wq[i][30]);
        e.vpf[c][s]  = 1'b1;
        e.q[c][s]    = wq[i][25:22];
        e.wg[c][s]   = wq[i][21:15];
        e.hs[c][s]   = wq[i][14:7];
        e.cpat[c][s] = wq[i][6:3];
      end
    end
    return e;
  endfunction

  task automatic send(input logic k, input logic [31:0] d);
    int n;
    n = gap_en ? int'($urandom_range(0, 3)) : 0;
    repeat (n) begin
      @(negedge clk);
      link_vld = 1'b0;
      link_k   = 1'b1;
      link_d   = {8'hBC, 24'($urandom)};
    end
    @(negedge clk);
    link_vld = 1'b1;
    link_k   = k;
    link_d   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      link_vld = 1'b0;
      link_k   = 1'b0;
      link_d   = '0;
    end
  endtask

  // Header, queued words, trailer (checksum optionally corrupted); checks strobe timing.
  task automatic send_frame(input string tag, input logic [11:0] bx, input logic [23:0] flip, input bit good);
    logic [23:0] x;
    x = '0;
    foreach (wq[i]) x ^= wq[i][23:0];
    if (good) begin
      last_exp = build(bx);
      sb.push_back(last_exp);
    end
    send(1'b1, hdr(bx, 5'(wq.size())));
    foreach (wq[i]) send(1'b0, wq[i]);
    send(1'b1, {8'hFD, x ^ flip});
    idle(1);
    chk({tag, "_stb"}, 256'(lct_stb), 256'(good));
    idle(1);
    chk({tag, "_stb_end"}, 256'(lct_stb), 256'(0));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && lct_stb === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stb: got lct_stb=1 bx_out=%0h expected no strobe", bx_out);
        end else begin
          e = sb.pop_front();
          chk_outs("sb", e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  logic [31:0] w0, w1;

  initial begin : stim
    zero_exp = '0;
    last_exp = '0;
    rst_n    = 1'b0;
    link_vld = 1'b0;
    link_k   = 1'b0;
    link_d   = '0;
    repeat (3) @(negedge clk);
    chk_outs("reset", zero_exp);
    chk("reset_stb", 256'(lct_stb), 256'(0));
    chk_err("reset", 0, 3'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic two-word frame
    w0 = mk(1'b1, 1'b0, 4'd3, 4'hA, 7'h15, 8'h40, 4'h5, 3'd3);
    w1 = mk(1'b1, 1'b1, 4'd8, 4'h7, 7'h7F, 8'hFF, 4'hC, 3'd3);
    wq = '{w0, w1};
    send_frame("basic", 12'h123, 24'h0, 1'b1);
    chk("basic_slot_q",  256'(q[3][0]),    256'(4'hA));
    chk("basic_slot_wg", 256'(wg[3][0]),   256'(7'h15));
    chk("basic_slot_hs", 256'(hstr[3][0]), 256'(8'h40));
    chk("basic_vpf",     256'(vpf),        256'(18'h20040));
    chk_err("basic", exp_cnt, 3'd0);

    // Same frame with checksum bit0 flipped
    send_frame("badchk", 12'h123, 24'h1, 1'b0);
    exp_cnt++;
    chk_outs("badchk_hold", last_exp);
    chk_err("badchk", exp_cnt, 3'd4);

    // Oversized word count, then a clean frame
    send(1'b1, hdr(12'h321, 5'd19));
    idle(2);
    exp_cnt++;
    chk_err("ncount", exp_cnt, 3'd1);
    wq = '{mk(1'b1, 1'b1, 4'd0, 4'h3, 7'h2A, 8'h11, 4'h9, 3'd6)};
    send_frame("after_n", 12'h456, 24'h0, 1'b1);

    // Full 18-word frame fills every slot
    wq = '{};
    for (int c = 0; c < 9; c++)
      for (int s = 0; s < 2; s++)
        wq.push_back(mk(1'b1, 1'(s), 4'(c), 4'(c), 7'(c * 9 + s), 8'(c * 16 + s + 1), 4'(15 - c), 3'd4));
    send_frame("full", 12'hABC, 24'h0, 1'b1);
    chk("full_vpf", 256'(vpf), 256'(18'h3FFFF));

    // vpf=0 word counts toward N but is not stored
    wq = '{mk(1'b0, 1'b0, 4'd5, 4'hF, 7'h7F, 8'hFF, 4'hF, 3'd1),
           mk(1'b1, 1'b0, 4'd5, 4'h2, 7'h01, 8'h02, 4'h3, 3'd1)};
    send_frame("novpf", 12'h011, 24'h0, 1'b1);
    chk("novpf_q", 256'(q[5][0]), 256'(4'h2));

    // Duplicate slot
    wq = '{mk(1'b1, 1'b0, 4'd2, 4'h1, 7'h01, 8'h01, 4'h1, 3'd2),
           mk(1'b1, 1'b0, 4'd2, 4'h2, 7'h02, 8'h02, 4'h2, 3'd2)};
    send_frame("dup", 12'h0F2, 24'h0, 1'b0);
    exp_cnt++;
    chk_outs("dup_hold", last_exp);
    chk_err("dup", exp_cnt, 3'd3);

    // Out-of-range cscid
    wq = '{mk(1'b1, 1'b0, 4'd12, 4'h1, 7'h01, 8'h01, 4'h1, 3'd0)};
    send_frame("cscid", 12'h000, 24'h0, 1'b0);
    exp_cnt++;
    chk_err("cscid", exp_cnt, 3'd2);

    // Resync: new header mid-frame, then empty frame
    send(1'b1, hdr(12'h200, 5'd2));
    send(1'b0, mk(1'b1, 1'b0, 4'd1, 4'h4, 7'h04, 8'h04, 4'h4, 3'd0));
    send(1'b1, hdr(12'h007, 5'd0));
    last_exp    = zero_exp;
    last_exp.bx = 12'h007;
    sb.push_back(last_exp);
    send(1'b1, {8'hFD, 24'h0});
    idle(1);
    chk("resync_stb", 256'(lct_stb), 256'(1));
    idle(1);
    exp_cnt++;
    chk_err("resync", exp_cnt, 3'd5);

    // bx3 mismatch against header
    wq = '{mk(1'b1, 1'b0, 4'd4, 4'h1, 7'h01, 8'h01, 4'h1, 3'd5)};
    send_frame("bxmis", 12'h002, 24'h0, 1'b0);
    exp_cnt++;
    chk_err("bxmis", exp_cnt, 3'd2);

    // Non-FD word in TRL
    send(1'b1, hdr(12'h010, 5'd0));
    send(1'b0, 32'h0);
    idle(2);
    exp_cnt++;
    chk_err("trl_nonfd", exp_cnt, 3'd4);

    // Unknown k-word in DATA, later trailer ignored in HUNT
    send(1'b1, hdr(12'h020, 5'd2));
    send(1'b0, mk(1'b1, 1'b0, 4'd6, 4'h6, 7'h06, 8'h06, 4'h6, 3'd0));
    send(1'b1, 32'h3C00_0000);
    send(1'b1, {8'hFD, 24'h0});
    idle(2);
    exp_cnt++;
    chk_err("kword", exp_cnt, 3'd5);
    chk_outs("kword_hold", last_exp);

    // Gapped version of the basic frame
    gap_en = 1'b1;
    wq = '{w0, w1};
    send_frame("gap", 12'h123, 24'h0, 1'b1);
    gap_en = 1'b0;

    // Reset mid-frame
    send(1'b1, hdr(12'h0AA, 5'd2));
    send(1'b0, mk(1'b1, 1'b0, 4'd7, 4'h7, 7'h07, 8'h07, 4'h7, 3'd2));
    @(negedge clk);
    link_vld = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    chk_outs("midrst", zero_exp);
    chk("midrst_stb", 256'(lct_stb), 256'(0));
    chk_err("midrst", 0, 3'd0);
    rst_n = 1'b1;
    send(1'b0, mk(1'b1, 1'b1, 4'd7, 4'h7, 7'h07, 8'h07, 4'h7, 3'd2));
    send(1'b1, {8'hFD, 24'h0});
    idle(2);
    chk("midrst_nostb", 256'(lct_stb), 256'(0));
    chk_outs("midrst_hold", zero_exp);

    idle(3);
    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
